// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, type codes and the injection FSM state type.
package noc_pkg;

    localparam int FLIT_W = 32;
    localparam int NUM_VC = 4;

    // Flit field positions
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 29;
    localparam int VC_MSB   = 28;
    localparam int VC_LSB   = 27;

    // Flit type codes carried in the type field
    typedef enum logic [2:0] {
        FT_HEAD = 3'b001,
        FT_BODY = 3'b010,
        FT_IDLE = 3'b011,
        FT_TAIL = 3'b100,
        FT_HT   = 3'b101
    } flit_type_e;

    // The router treats this pattern as "no flit this cycle"
    localparam logic [FLIT_W-1:0] IDLE_FLIT = 32'h6000_0000;

    // Injection scheduler states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } inj_state_e;

    // A flit can open a packet if it is a head or a single-flit head+tail
    function automatic logic is_head(input logic [FLIT_W-1:0] flit);
        return (flit[TYPE_MSB:TYPE_LSB] == FT_HEAD) || (flit[TYPE_MSB:TYPE_LSB] == FT_HT);
    endfunction

    // A flit closes a packet if it is a tail or a single-flit head+tail
    function automatic logic is_tail(input logic [FLIT_W-1:0] flit);
        return (flit[TYPE_MSB:TYPE_LSB] == FT_TAIL) || (flit[TYPE_MSB:TYPE_LSB] == FT_HT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan the requests starting at the pointer and wrapping, keep the first hit
    always_comb begin
        logic found;
        int   j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!found && req_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
                found      = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/core_inject_arbiter.sv
// Per-tile injection scheduler: shares the router core port among N_REQ sources,
// round-robin per packet, with per-packet virtual-channel allocation.
module core_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_PKT = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [FLIT_W-1:0]        req_flit [N_REQ],
    output logic [N_REQ-1:0]         req_ready,
    input  logic [NUM_VC-1:0]        vc_full,
    output logic [FLIT_W-1:0]        inj_flit,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_nohead,
    output logic                     err_trunc
);

    localparam int          GW        = $clog2(N_REQ);
    localparam logic [7:0]  MAX_PKT_C = 8'(MAX_PKT);

    inj_state_e        state_q, state_d;
    logic [GW-1:0]     grantId_q, grantId_d;
    logic [1:0]        vcSel_q, vcSel_d;
    logic [GW-1:0]     rrReq_q, rrReq_d;
    logic [1:0]        rrVc_q, rrVc_d;
    logic [7:0]        flitCnt_q, flitCnt_d;
    logic [FLIT_W-1:0] injFlit_q, injFlit_d;
    logic              errNohead_q, errNohead_d;
    logic              errTrunc_q, errTrunc_d;

    logic [N_REQ-1:0]  headReq;
    logic [N_REQ-1:0]  strayReq;
    logic [N_REQ-1:0]  strayOh;
    logic [N_REQ-1:0]  reqGrantOh;
    logic [GW-1:0]     reqIdx;
    logic              reqAny;
    logic [NUM_VC-1:0] vcGrantOh;
    logic [1:0]        vcIdx;
    logic              vcAny;
    logic [FLIT_W-1:0] ownFlit;
    logic              accept;
    logic [N_REQ-1:0]  readyComb;
    logic              unusedGrants;

    // Classify offered flits: heads compete for the port, anything else offered in IDLE is stray
    always_comb begin
        headReq  = '0;
        strayReq = '0;
        for (int k = 0; k < N_REQ; k++) begin
            headReq[k]  = req_valid[k] && is_head(req_flit[k]);
            strayReq[k] = req_valid[k] && !is_head(req_flit[k]);
        end
    end

    // Lowest set bit of the stray vector: only one stray flit is dropped per cycle
    assign strayOh = strayReq & (~strayReq + N_REQ'(1));

    rr_arbiter #(.N(N_REQ)) u_req_arb (
        .req_i   (headReq),
        .ptr_i   (rrReq_q),
        .grant_o (reqGrantOh),
        .idx_o   (reqIdx),
        .any_o   (reqAny)
    );

    rr_arbiter #(.N(NUM_VC)) u_vc_arb (
        .req_i   (~vc_full),
        .ptr_i   (rrVc_q),
        .grant_o (vcGrantOh),
        .idx_o   (vcIdx),
        .any_o   (vcAny)
    );

    // The registers are loaded from the index form; the one-hot grants are not needed here
    assign unusedGrants = ^{reqGrantOh, vcGrantOh};

    assign ownFlit = req_flit[grantId_q];
    assign accept  = req_valid[grantId_q] && !vc_full[vcSel_q];

    // Next-state logic for the packet FSM, pointers, counters and the output flit
    always_comb begin
        state_d     = state_q;
        grantId_d   = grantId_q;
        vcSel_d     = vcSel_q;
        rrReq_d     = rrReq_q;
        rrVc_d      = rrVc_q;
        flitCnt_d   = flitCnt_q;
        errNohead_d = errNohead_q;
        errTrunc_d  = errTrunc_q;
        injFlit_d   = IDLE_FLIT;
        readyComb   = '0;
        case (state_q)
            ST_IDLE: begin
                if (reqAny && vcAny) begin
                    state_d   = ST_SEND;
                    grantId_d = reqIdx;
                    vcSel_d   = vcIdx;
                    flitCnt_d = '0;
                end else if (|strayReq) begin
                    readyComb   = strayOh;
                    errNohead_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    readyComb[grantId_q]     = 1'b1;
                    flitCnt_d                = flitCnt_q + 8'd1;
                    injFlit_d                = ownFlit;
                    injFlit_d[VC_MSB:VC_LSB] = vcSel_q;
                    if (is_tail(ownFlit) || ((flitCnt_q + 8'd1) == MAX_PKT_C)) begin
                        if (!is_tail(ownFlit)) begin
                            injFlit_d[TYPE_MSB:TYPE_LSB] = FT_TAIL;
                            errTrunc_d                   = 1'b1;
                        end
                        state_d   = ST_IDLE;
                        rrReq_d   = (grantId_q == GW'(N_REQ - 1)) ? '0 : grantId_q + GW'(1);
                        rrVc_d    = vcSel_q + 2'd1;
                        flitCnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any partial packet without emitting a tail
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            grantId_q   <= '0;
            vcSel_q     <= '0;
            rrReq_q     <= '0;
            rrVc_q      <= '0;
            flitCnt_q   <= '0;
            injFlit_q   <= IDLE_FLIT;
            errNohead_q <= 1'b0;
            errTrunc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grantId_q   <= grantId_d;
            vcSel_q     <= vcSel_d;
            rrReq_q     <= rrReq_d;
            rrVc_q      <= rrVc_d;
            flitCnt_q   <= flitCnt_d;
            injFlit_q   <= injFlit_d;
            errNohead_q <= errNohead_d;
            errTrunc_q  <= errTrunc_d;
        end
    end

    // Ready is held low while reset is asserted so no flit is consumed during reset
    assign req_ready  = clr ? readyComb : '0;
    assign inj_flit   = injFlit_q;
    assign grant_id   = grantId_q;
    assign busy       = (state_q == ST_SEND);
    assign err_nohead = errNohead_q;
    assign err_trunc  = errTrunc_q;

endmodule

// File: tb/tb_core_inject_arbiter.sv
// Self-checking bench for core_inject_arbiter: vector table plus multi-cycle sequences.
module tb_core_inject_arbiter;
    import noc_pkg::*;

    localparam int N_REQ   = 4;
    localparam int MAX_PKT = 16;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req_valid;
    logic [31:0] req_flit [N_REQ];
    logic [3:0]  req_ready;
    logic [3:0]  vc_full;
    logic [31:0] inj_flit;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_nohead;
    logic        err_trunc;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]       valid;
        logic [3:0][31:0] flit;
        logic [3:0]       full;
        logic [3:0]       expReady;
        logic [31:0]      expInj;
        logic             expBusy;
        logic [1:0]       expGrant;
        logic             expNh;
        logic             expTr;
    } vec_t;

    vec_t vecs[$];

    core_inject_arbiter #(.N_REQ(N_REQ), .MAX_PKT(MAX_PKT)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_flit   (req_flit),
        .req_ready  (req_ready),
        .vc_full    (vc_full),
        .inj_flit   (inj_flit),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_nohead (err_nohead),
        .err_trunc  (err_trunc)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Hard stop in case a sequence stalls forever
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mkFlit(input logic [2:0] t, input logic [7:0] tag,
                                           input logic [7:0] src, input logic [7:0] dst);
        return {t, 2'b00, 3'b000, tag, src, dst};
    endfunction

    function automatic logic [31:0] onVc(input logic [31:0] f, input logic [1:0] vc);
        logic [31:0] r;
        r        = f;
        r[28:27] = vc;
        return r;
    endfunction

    function automatic logic [31:0] asTail(input logic [31:0] f);
        logic [31:0] r;
        r        = f;
        r[31:29] = 3'b100;
        return r;
    endfunction

    function automatic logic [3:0][31:0] pack4(input logic [31:0] f0, input logic [31:0] f1,
                                               input logic [31:0] f2, input logic [31:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    function automatic logic [31:0] truncFlit(input int i);
        logic [2:0] t;
        t = (i == 0) ? 3'b001 : ((i == 19) ? 3'b100 : 3'b010);
        return mkFlit(t, 8'(i), 8'h01, 8'h55);
    endfunction

    function automatic void addVec(input logic [3:0] v, input logic [3:0][31:0] f, input logic [3:0] full,
                                   input logic [3:0] er, input logic [31:0] ei, input logic eb,
                                   input logic [1:0] eg, input logic enh, input logic etr);
        vec_t x;
        x.valid    = v;
        x.flit     = f;
        x.full     = full;
        x.expReady = er;
        x.expInj   = ei;
        x.expBusy  = eb;
        x.expGrant = eg;
        x.expNh    = enh;
        x.expTr    = etr;
        vecs.push_back(x);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0][31:0] f, input logic [3:0] full);
        @(posedge clk);
        #1;
        req_valid = v;
        for (int r = 0; r < N_REQ; r++) req_flit[r] = f[r];
        vc_full = full;
    endtask

    // Compare all outputs on the falling edge of the same cycle
    task automatic checkOutput(input string name, input logic [3:0] er, input logic [31:0] ei,
                               input logic eb, input logic [1:0] eg, input logic enh, input logic etr);
        @(negedge clk);
        checkVal({name, ".ready"}, 32'(req_ready), 32'(er));
        checkVal({name, ".inj"}, inj_flit, ei);
        checkVal({name, ".busy"}, 32'(busy), 32'(eb));
        if (eb) checkVal({name, ".grant"}, 32'(grant_id), 32'(eg));
        checkVal({name, ".nohead"}, 32'(err_nohead), 32'(enh));
        checkVal({name, ".trunc"}, 32'(err_trunc), 32'(etr));
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        clr       = 1'b0;
        req_valid = '0;
        vc_full   = '0;
        @(posedge clk);
        #2;
        clr = 1'b1;
    endtask

    initial begin
        logic [31:0] H0, B0, T0, H1, B1, T1, B2, B3, H4, T4, HT0, HT3, HT2, HA1, HA3, BA3, HB0, z, exp;
        logic [3:0]  lastReady;
        int          phase [N_REQ];
        int          pktNo [N_REQ];
        int          k, m, idx, outIdx;

        z   = IDLE_FLIT;
        H0  = mkFlit(3'b001, 8'h01, 8'h00, 8'h20);
        B0  = mkFlit(3'b010, 8'h02, 8'h00, 8'h20);
        T0  = mkFlit(3'b100, 8'h03, 8'h00, 8'h20);
        H1  = mkFlit(3'b001, 8'h11, 8'h00, 8'h21);
        B1  = mkFlit(3'b010, 8'h12, 8'h00, 8'h21);
        T1  = mkFlit(3'b100, 8'h13, 8'h00, 8'h21);
        B2  = mkFlit(3'b010, 8'h21, 8'h02, 8'h22);
        B3  = mkFlit(3'b010, 8'h22, 8'h03, 8'h23);
        H4  = mkFlit(3'b001, 8'h41, 8'h00, 8'h24);
        T4  = mkFlit(3'b100, 8'h42, 8'h00, 8'h24);
        HT0 = mkFlit(3'b101, 8'h30, 8'h00, 8'h11);
        HT3 = mkFlit(3'b101, 8'h31, 8'h03, 8'h22);
        HT2 = mkFlit(3'b101, 8'h32, 8'h02, 8'h33);
        HA1 = mkFlit(3'b001, 8'h51, 8'h01, 8'h44);
        HA3 = mkFlit(3'b001, 8'h53, 8'h03, 8'h44);
        BA3 = mkFlit(3'b010, 8'h54, 8'h03, 8'h44);
        HB0 = mkFlit(3'b101, 8'h60, 8'h00, 8'h45);

        // Single requester, 3-flit packet on VC0
        addVec(4'b0001, pack4(H0, z, z, z), 4'b0000, 4'b0000, z,            1'b0, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(H0, z, z, z), 4'b0000, 4'b0001, z,            1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(B0, z, z, z), 4'b0000, 4'b0001, onVc(H0, 0),  1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(T0, z, z, z), 4'b0000, 4'b0001, onVc(B0, 0),  1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, onVc(T0, 0),  1'b0, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, z,            1'b0, 2'd0, 1'b0, 1'b0);
        // Backpressure on VC1 for three cycles, other VCs irrelevant
        addVec(4'b0001, pack4(H1, z, z, z), 4'b0000, 4'b0000, z,            1'b0, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(H1, z, z, z), 4'b0000, 4'b0001, z,            1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(B1, z, z, z), 4'b0000, 4'b0001, onVc(H1, 1),  1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(T1, z, z, z), 4'b0010, 4'b0000, onVc(B1, 1),  1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(T1, z, z, z), 4'b0010, 4'b0000, z,            1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(T1, z, z, z), 4'b0010, 4'b0000, z,            1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, pack4(T1, z, z, z), 4'b1101, 4'b0001, z,            1'b1, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, onVc(T1, 1),  1'b0, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, z,            1'b0, 2'd0, 1'b0, 1'b0);
        // Stray body flits in IDLE are dropped, lowest index first, never while a head wins
        addVec(4'b0100, pack4(z, z, B2, z), 4'b0000, 4'b0100, z,            1'b0, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, z,            1'b0, 2'd0, 1'b1, 1'b0);
        addVec(4'b1100, pack4(z, z, B2, B3), 4'b0000, 4'b0100, z,           1'b0, 2'd0, 1'b1, 1'b0);
        addVec(4'b0101, pack4(H4, z, B2, z), 4'b0000, 4'b0000, z,           1'b0, 2'd0, 1'b1, 1'b0);
        addVec(4'b0101, pack4(H4, z, B2, z), 4'b0000, 4'b0001, z,           1'b1, 2'd0, 1'b1, 1'b0);
        addVec(4'b0101, pack4(T4, z, B2, z), 4'b0000, 4'b0001, onVc(H4, 2), 1'b1, 2'd0, 1'b1, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, onVc(T4, 2),  1'b0, 2'd0, 1'b1, 1'b0);
        addVec(4'b0000, pack4(z, z, z, z),  4'b0000, 4'b0000, z,            1'b0, 2'd0, 1'b1, 1'b0);

        // Reset values, with a body flit offered that must not be consumed
        clr       = 1'b0;
        vc_full   = '0;
        req_valid = 4'b0001;
        req_flit[0] = B0;
        for (int r = 1; r < N_REQ; r++) req_flit[r] = IDLE_FLIT;
        checkOutput("reset", 4'b0000, IDLE_FLIT, 1'b0, 2'd0, 1'b0, 1'b0);
        checkVal("reset.grant0", 32'(grant_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #2;
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].flit, vecs[i].full);
            checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expInj,
                        vecs[i].expBusy, vecs[i].expGrant, vecs[i].expNh, vecs[i].expTr);
        end

        // Contention: four sources offering 2-flit packets back to back
        doReset();
        lastReady = '0;
        for (int r = 0; r < N_REQ; r++) begin
            phase[r] = 0;
            pktNo[r] = 0;
        end
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < N_REQ; r++) begin
                if (lastReady[r]) begin
                    if (phase[r] == 1) begin
                        phase[r] = 0;
                        pktNo[r]++;
                    end else begin
                        phase[r] = 1;
                    end
                end
                req_valid[r] = 1'b1;
                req_flit[r]  = mkFlit((phase[r] != 0) ? 3'b100 : 3'b001, 8'(pktNo[r]), 8'(r), 8'h40 + 8'(r));
            end
            vc_full = '0;
            @(negedge clk);
            lastReady = req_ready;
            exp = IDLE_FLIT;
            if (cyc >= 2) begin
                k = (cyc - 2) / 3;
                m = (cyc - 2) % 3;
                if (m == 0) exp = onVc(mkFlit(3'b001, 8'(k / 4), 8'(k % 4), 8'h40 + 8'(k % 4)), 2'(k % 4));
                if (m == 1) exp = onVc(mkFlit(3'b100, 8'(k / 4), 8'(k % 4), 8'h40 + 8'(k % 4)), 2'(k % 4));
            end
            checkVal($sformatf("contention.cyc%0d", cyc), inj_flit, exp);
        end

        // All VCs full: no grant until one frees, then first free VC at or after the pointer
        doReset();
        applyStimulus(4'b0001, pack4(HT0, z, z, z), 4'b0000);
        checkOutput("full.pre0", 4'b0000, z, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0001, pack4(HT0, z, z, z), 4'b0000);
        checkOutput("full.pre1", 4'b0001, z, 1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, pack4(z, z, z, z), 4'b0000);
        checkOutput("full.pre2", 4'b0000, onVc(HT0, 0), 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, pack4(z, z, z, HT3), 4'b1111);
            checkOutput($sformatf("full.all%0d", i), 4'b0000, z, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        applyStimulus(4'b1000, pack4(z, z, z, HT3), 4'b1010);
        checkOutput("full.free0", 4'b0000, z, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1000, pack4(z, z, z, HT3), 4'b1010);
        checkOutput("full.free1", 4'b1000, z, 1'b1, 2'd3, 1'b0, 1'b0);
        applyStimulus(4'b0000, pack4(z, z, z, z), 4'b0000);
        checkOutput("full.out", 4'b0000, onVc(HT3, 2), 1'b0, 2'd0, 1'b0, 1'b0);

        // Truncation: a 20-flit packet from req1 is cut at MAX_PKT flits on VC3
        idx       = 0;
        outIdx    = 0;
        lastReady = '0;
        for (int cyc = 0; cyc < 60 && outIdx < MAX_PKT; cyc++) begin
            @(posedge clk);
            #1;
            if (lastReady[1]) idx++;
            req_valid   = (idx < MAX_PKT) ? 4'b0010 : 4'b0000;
            req_flit[1] = truncFlit(idx);
            vc_full     = '0;
            @(negedge clk);
            lastReady = req_ready;
            if (inj_flit !== IDLE_FLIT) begin
                exp = onVc(truncFlit(outIdx), 2'd3);
                if (outIdx == MAX_PKT - 1) exp = asTail(exp);
                checkVal($sformatf("trunc.flit%0d", outIdx), inj_flit, exp);
                if (outIdx == MAX_PKT - 2) checkVal("trunc.early", 32'(err_trunc), 32'd0);
                outIdx++;
            end
        end
        checkVal("trunc.count", 32'(outIdx), 32'(MAX_PKT));
        checkVal("trunc.busy", 32'(busy), 32'd0);
        checkVal("trunc.err", 32'(err_trunc), 32'd1);
        checkVal("trunc.nohead", 32'(err_nohead), 32'd0);

        // Reset mid-packet: outputs drop at once, pointers restart at req0 / VC0
        applyStimulus(4'b0100, pack4(z, z, HT2, z), 4'b0000);
        checkOutput("mid.ht0", 4'b0000, z, 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0100, pack4(z, z, HT2, z), 4'b0000);
        checkOutput("mid.ht1", 4'b0100, z, 1'b1, 2'd2, 1'b0, 1'b1);
        applyStimulus(4'b0000, pack4(z, z, z, z), 4'b0000);
        checkOutput("mid.ht2", 4'b0000, onVc(HT2, 0), 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b1010, pack4(z, HA1, z, HA3), 4'b0000);
        checkOutput("mid.p0", 4'b0000, z, 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b1010, pack4(z, HA1, z, HA3), 4'b0000);
        checkOutput("mid.p1", 4'b1000, z, 1'b1, 2'd3, 1'b0, 1'b1);
        applyStimulus(4'b1010, pack4(z, HA1, z, BA3), 4'b0000);
        checkOutput("mid.p2", 4'b1000, onVc(HA3, 1), 1'b1, 2'd3, 1'b0, 1'b1);
        #2;
        clr = 1'b0;
        #1;
        checkVal("mid.rst.inj", inj_flit, IDLE_FLIT);
        checkVal("mid.rst.busy", 32'(busy), 32'd0);
        checkVal("mid.rst.grant", 32'(grant_id), 32'd0);
        checkVal("mid.rst.ready", 32'(req_ready), 32'd0);
        checkVal("mid.rst.trunc", 32'(err_trunc), 32'd0);
        checkVal("mid.rst.nohead", 32'(err_nohead), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #2;
        clr = 1'b1;
        applyStimulus(4'b1001, pack4(HB0, z, z, HA3), 4'b0000);
        checkOutput("post.p0", 4'b0000, z, 1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1001, pack4(HB0, z, z, HA3), 4'b0000);
        checkOutput("post.p1", 4'b0001, z, 1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, pack4(z, z, z, z), 4'b0000);
        checkOutput("post.p2", 4'b0000, onVc(HB0, 0), 1'b0, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
